// File: rtl/resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : resp_pkg
//  Description : Shared response codes, fixed payloads and transmit FSM
//                states for the response framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package resp_pkg;

    // Response codes carried in the middle byte of every frame
    localparam logic [7:0] c_code_fault    = 8'h00;
    localparam logic [7:0] c_code_ok       = 8'h01;
    localparam logic [7:0] c_code_humidity = 8'h02;
    localparam logic [7:0] c_code_temp     = 8'h03;
    localparam logic [7:0] c_code_temp_off = 8'h04;
    localparam logic [7:0] c_code_hum_off  = 8'h05;
    localparam logic [7:0] c_code_invalid  = 8'h06;

    // Fixed payloads, placed in the top byte of the payload field
    localparam logic [7:0] c_pay_fault     = 8'h80;
    localparam logic [7:0] c_pay_ok        = 8'hC0;
    localparam logic [7:0] c_pay_temp_off  = 8'hE0;
    localparam logic [7:0] c_pay_hum_off   = 8'hF0;

    // Transmit FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/resp_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : resp_framer_if
//  Description : Request, transmitter and status signals of the response
//                framer. slave = framer view, master = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface resp_framer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int FRAME_W = ADDR_W + 8 + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                En;
    logic [5:0]          comandos;
    logic [ADDR_W-1:0]   endereco;
    logic [DATA_W-1:0]   data_sensor;
    logic                req_ready;
    logic                start_transmitter;
    logic [FRAME_W-1:0]  data_transmitter;
    logic                data_transmitted;
    logic                d_done;
    logic                invalid_cmd;
    logic                overflow;
    logic [CNT_W-1:0]    fifo_count;

    modport slave (
        input  En, comandos, endereco, data_sensor, data_transmitted,
        output req_ready, start_transmitter, data_transmitter,
               d_done, invalid_cmd, overflow, fifo_count
    );

    modport master (
        output En, comandos, endereco, data_sensor, data_transmitted,
        input  req_ready, start_transmitter, data_transmitter,
               d_done, invalid_cmd, overflow, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : resp_fifo
//  Description : Synchronous first-word-fall-through FIFO with full, empty
//                and occupancy count. DEPTH must be a power of two >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic [WIDTH-1:0]             i_data,
    input  wire logic                         i_pop,
    output logic      [WIDTH-1:0]             o_data,
    output logic                              o_full,
    output logic                              o_empty,
    output logic      [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : resp_framer
//  Description : Encodes one-hot response commands into {address, code,
//                payload} frames, buffers them and hands them one at a time
//                to the UART transmitter with a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module resp_framer
    import resp_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    resp_framer_if.slave bus
);
    localparam int FRAME_W = ADDR_W + 8 + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [7:0]         w_code;
    logic [DATA_W-1:0]  w_payload;
    logic [FRAME_W-1:0] w_frame;
    logic               w_onehot;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [FRAME_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;

    logic               r_invalid;
    logic               r_overflow;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic [FRAME_W-1:0] r_data;
    logic [FRAME_W-1:0] w_data_nxt;
    logic               r_done;
    logic               w_done_nxt;

    // Acceptance looks only at the registered count, so a pop on the same
    // edge never opens a slot for a request that arrives while full.
    assign w_push   = bus.En && !w_full;
    assign w_onehot = $onehot(bus.comandos);
    assign w_frame  = {bus.endereco, w_code, w_payload};

    // Command encoder: fixed payloads sit in the top byte, rest zero
    always_comb begin
        w_code    = c_code_invalid;
        w_payload = '1;
        case (bus.comandos)
            6'b000001: begin
                w_code                 = c_code_fault;
                w_payload              = '0;
                w_payload[DATA_W-1 -: 8] = c_pay_fault;
            end
            6'b000010: begin
                w_code                 = c_code_ok;
                w_payload              = '0;
                w_payload[DATA_W-1 -: 8] = c_pay_ok;
            end
            6'b000100: begin
                w_code    = c_code_humidity;
                w_payload = bus.data_sensor;
            end
            6'b001000: begin
                w_code    = c_code_temp;
                w_payload = bus.data_sensor;
            end
            6'b010000: begin
                w_code                 = c_code_temp_off;
                w_payload              = '0;
                w_payload[DATA_W-1 -: 8] = c_pay_temp_off;
            end
            6'b100000: begin
                w_code                 = c_code_hum_off;
                w_payload              = '0;
                w_payload[DATA_W-1 -: 8] = c_pay_hum_off;
            end
            default: begin
                w_code    = c_code_invalid;
                w_payload = '1;
            end
        endcase
    end

    resp_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_frame),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Single-cycle status pulses for rejected and malformed requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_invalid  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_invalid  <= w_push && !w_onehot;
            r_overflow <= bus.En && w_full;
        end
    end

    // Transmit FSM state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_start <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Transmit FSM next-state: pop in IDLE, hold in SEND, pulse done in DONE
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_start_nxt = 1'b1;
                    w_data_nxt  = w_head;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.data_transmitted) begin
                    w_start_nxt = 1'b0;
                    w_data_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_start_nxt = 1'b0;
                w_data_nxt  = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready         = !w_full;
    assign bus.fifo_count        = w_count;
    assign bus.start_transmitter = r_start;
    assign bus.data_transmitter  = r_data;
    assign bus.d_done            = r_done;
    assign bus.invalid_cmd       = r_invalid;
    assign bus.overflow          = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_resp_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resp_framer
//  Description : Self-checking bench for resp_framer with a frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_resp_framer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    resp_framer_if #(.ADDR_W(8), .DATA_W(8),  .DEPTH(4)) bus   ();
    resp_framer_if #(.ADDR_W(8), .DATA_W(12), .DEPTH(4)) bus12 ();

    resp_framer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    resp_framer #(.ADDR_W(8), .DATA_W(12), .DEPTH(4)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    int          n_checks    = 0;
    int          n_errors    = 0;
    int          n_acks      = 0;
    int          n_done_seen = 0;
    logic        prev_start  = 1'b0;
    logic [23:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [5:0] c, input logic [7:0] a, input logic [7:0] d);
        case (c)
            6'b000001: return {a, 8'h00, 8'h80};
            6'b000010: return {a, 8'h01, 8'hC0};
            6'b000100: return {a, 8'h02, d};
            6'b001000: return {a, 8'h03, d};
            6'b010000: return {a, 8'h04, 8'hE0};
            6'b100000: return {a, 8'h05, 8'hF0};
            default:   return {a, 8'h06, 8'hFF};
        endcase
    endfunction

    // Scoreboard: every new frame is compared with the oldest expected one
    always @(negedge clk) begin
        if (bus.d_done) n_done_seen++;
        if (bus.start_transmitter && !prev_start) begin
            if (exp_q.size() == 0) chk("unexpected_frame", 64'(exp_q.size()), 64'd1);
            else                   chk("frame", 64'(bus.data_transmitter), 64'(exp_q.pop_front()));
        end
        prev_start = bus.start_transmitter;
    end

    task automatic send_req(input logic [5:0] c, input logic [7:0] a, input logic [7:0] d, input logic acc);
        bus.En          = 1'b1;
        bus.comandos    = c;
        bus.endereco    = a;
        bus.data_sensor = d;
        chk("req_ready", 64'(bus.req_ready), 64'(acc));
        if (acc) exp_q.push_back(model(c, a, d));
        @(negedge clk);
        bus.En = 1'b0;
        chk("invalid_cmd", 64'(bus.invalid_cmd), 64'(acc && ($countones(c) != 1)));
        chk("overflow", 64'(bus.overflow), 64'(!acc));
    endtask

    task automatic ack();
        int t = 0;
        while (!bus.start_transmitter && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.start_transmitter) begin
            chk("ack_timeout", 64'(bus.start_transmitter), 64'd1);
            return;
        end
        bus.data_transmitted = 1'b1;
        @(negedge clk);
        bus.data_transmitted = 1'b0;
        n_acks++;
        chk("start_clr", 64'(bus.start_transmitter), 64'd0);
        chk("data_clr", 64'(bus.data_transmitter), 64'd0);
        chk("d_done_hi", 64'(bus.d_done), 64'd1);
        @(negedge clk);
        chk("d_done_lo", 64'(bus.d_done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Main stimulus sequence
    initial begin
        logic [5:0] cmds [8];
        int         done_before;

        bus.En = 1'b0;   bus.comandos = '0;   bus.endereco = '0;
        bus.data_sensor = '0; bus.data_transmitted = 1'b0;
        bus12.En = 1'b0; bus12.comandos = '0; bus12.endereco = '0;
        bus12.data_sensor = '0; bus12.data_transmitted = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(bus.start_transmitter), 64'd0);
        chk("rst_data", 64'(bus.data_transmitter), 64'd0);
        chk("rst_d_done", 64'(bus.d_done), 64'd0);
        chk("rst_invalid", 64'(bus.invalid_cmd), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Temperature request, latency and handshake
        send_req(6'b001000, 8'h41, 8'h19, 1'b1);
        chk("lat_start0", 64'(bus.start_transmitter), 64'd0);
        chk("lat_count1", 64'(bus.fifo_count), 64'd1);
        @(negedge clk);
        chk("lat_start1", 64'(bus.start_transmitter), 64'd1);
        chk("temp_frame", 64'(bus.data_transmitter), 64'h410319);
        chk("lat_count0", 64'(bus.fifo_count), 64'd0);
        ack();

        // All command kinds including zero and multi-hot
        cmds = '{6'b000010, 6'b000110, 6'b000000, 6'b000100,
                 6'b000001, 6'b010000, 6'b100000, 6'b111111};
        for (int i = 0; i < 8; i++) begin
            send_req(cmds[i], 8'(8'h60 + i), 8'($urandom_range(0, 255)), 1'b1);
            ack();
        end

        // Overflow: transmitter stalls, five accepted, sixth dropped
        for (int i = 0; i < 5; i++) begin
            send_req(6'b001000, 8'(8'h50 + i), 8'(8'h10 + i), 1'b1);
        end
        chk("full_count", 64'(bus.fifo_count), 64'd4);
        send_req(6'b000100, 8'h5F, 8'hAA, 1'b0);
        chk("ovf_count", 64'(bus.fifo_count), 64'd4);
        @(negedge clk);
        chk("ovf_lo", 64'(bus.overflow), 64'd0);
        repeat (5) ack();
        chk("drain_q", 64'(exp_q.size()), 64'd0);
        chk("drain_count", 64'(bus.fifo_count), 64'd0);

        // Reset while SEND with two frames queued
        send_req(6'b000010, 8'h70, 8'h00, 1'b1);
        send_req(6'b000100, 8'h71, 8'h33, 1'b1);
        send_req(6'b001000, 8'h72, 8'h44, 1'b1);
        chk("pre_rst_start", 64'(bus.start_transmitter), 64'd1);
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd2);
        done_before = n_done_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_start", 64'(bus.start_transmitter), 64'd0);
        chk("mid_rst_data", 64'(bus.data_transmitter), 64'd0);
        chk("mid_rst_count", 64'(bus.fifo_count), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd1);
        bus.data_transmitted = 1'b1;
        @(negedge clk);
        bus.data_transmitted = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(bus.start_transmitter), 64'd0);
        end
        chk("post_rst_no_done", 64'(n_done_seen), 64'(done_before));

        // Wider payload: fixed bytes left-aligned, invalid is all ones
        bus12.En = 1'b1; bus12.comandos = 6'b000010; bus12.endereco = 8'h42;
        @(negedge clk);
        bus12.En = 1'b0;
        chk("w12_ok_invalid", 64'(bus12.invalid_cmd), 64'd0);
        @(negedge clk);
        chk("w12_ok_start", 64'(bus12.start_transmitter), 64'd1);
        chk("w12_ok_frame", 64'(bus12.data_transmitter), 64'h4201C00);
        bus12.data_transmitted = 1'b1;
        @(negedge clk);
        bus12.data_transmitted = 1'b0;
        chk("w12_done", 64'(bus12.d_done), 64'd1);
        bus12.En = 1'b1; bus12.comandos = 6'b000000; bus12.endereco = 8'h43;
        @(negedge clk);
        bus12.En = 1'b0;
        chk("w12_bad_invalid", 64'(bus12.invalid_cmd), 64'd1);
        @(negedge clk);
        chk("w12_bad_frame", 64'(bus12.data_transmitter), 64'h4306FFF);

        chk("done_count", 64'(n_done_seen), 64'(n_acks));
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resp_framer.md
# resp_framer

Parametrised response framer between the sensor interface and the UART transmitter. Accepts one-hot response commands with sensor address and measurement, encodes each into a frame `{address, response code, payload}`, queues frames in an internal FIFO and serialises them to the transmitter with a start/done handshake. Replaces the single-shot response decoder: it buffers responses, has configurable address and data widths, and flags invalid commands and overflow.

## Interface
- `ADDR_W`, default 8: width of `endereco` (ASCII sensor address).
- `DATA_W`, default 8: payload width; must be at least 8.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- Derived: `FRAME_W = ADDR_W + 8 + DATA_W`; `CNT_W = $clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `En`  in  1  response request valid.
- `comandos`  in  6  one-hot response command.
- `endereco`  in  ADDR_W  sensor address.
- `data_sensor`  in  DATA_W  measurement value.
- `req_ready`  out  1  FIFO not full.
- `start_transmitter`  out  1  frame valid to the transmitter; held until done.
- `data_transmitter`  out  FRAME_W  frame being sent.
- `data_transmitted`  in  1  transmitter finished the current frame.
- `d_done`  out  1  one-cycle pulse per completed frame.
- `invalid_cmd`  out  1  one-cycle pulse when an accepted command was not one-hot.
- `overflow`  out  1  one-cycle pulse when a request was dropped because the FIFO was full.
- `fifo_count`  out  CNT_W  queued frames, excluding the one in flight.

## Operation
- Accept when `En && req_ready`. `comandos`, `endereco` and `data_sensor` are sampled and encoded on the same edge, and the frame is pushed.
- Encoding: code in the middle byte. A fixed payload sits in the top 8 bits of the payload field, with the lower `DATA_W-8` bits zero.
  - bit0, sensor fault: code 0x00, payload 0x80.
  - bit1, sensor OK: code 0x01, payload 0xC0.
  - bit2, humidity: code 0x02, payload `data_sensor`.
  - bit3, temperature: code 0x03, payload `data_sensor`.
  - bit4, continuous temperature off: code 0x04, payload 0xE0.
  - bit5, continuous humidity off: code 0x05, payload 0xF0.
  - Zero or multi-hot command: code 0x06, payload all ones, and `invalid_cmd` pulses.
- `En` while full: request dropped, `overflow` pulses, FIFO unchanged.
- Transmit FSM:
  - IDLE: if FIFO is non-empty, pop, load `data_transmitter`, set `start_transmitter`, go to SEND.
  - SEND: hold frame and `start_transmitter`. When `data_transmitted` is sampled high, clear `start_transmitter`, zero `data_transmitter`, set `d_done`, go to DONE.
  - DONE: clear `d_done`, go to IDLE.
- `data_transmitted` is ignored in IDLE and DONE.
- `req_ready` is based on the registered count only. A pop on the same edge does not allow an accept while full.
- Simultaneous push and pop on a non-full FIFO: count is unchanged, both operations take effect.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `start_transmitter`=0, `data_transmitter`=0, `d_done`=0, `invalid_cmd`=0, `overflow`=0, `fifo_count`=0, `req_ready`=1. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-frame abandons the in-flight frame and all queued frames. `start_transmitter` is low after the reset edge.
- Latency: request accepted at edge k with FIFO empty and FSM in IDLE → `start_transmitter`=1 and frame valid after edge k+1.
- `data_transmitted` sampled at edge j → `start_transmitter`=0 and `d_done`=1 after edge j; `d_done`=0 after j+1; next queued frame starts after j+2.
- `invalid_cmd` and `overflow` are high for the single cycle following the offending edge.

## Structure
- Package `resp_pkg`:
  - response code constants 0x00–0x06;
  - fixed payload constants 0x80, 0xC0, 0xE0, 0xF0;
  - FSM state enum {IDLE, SEND, DONE}.
- Sub-module `resp_fifo`: synchronous FIFO parametrised by `WIDTH`/`DEPTH`, with full, empty and count outputs.
- Encoder logic and transmit FSM live in `resp_framer`.

## Test plan
- Temperature: `endereco`=0x41, `comandos`=0b001000, `data_sensor`=0x19 → after one edge `data_transmitter`=0x410319, `start_transmitter`=1. Assert `data_transmitted` → `d_done` pulses once.
- Sensor OK: `comandos`=0b000010 → frame middle byte 0x01, payload 0xC0. Repeat with `DATA_W`=12 → payload 0xC00.
- Invalid command: `comandos`=0b000110 → `invalid_cmd` pulse, frame code 0x06, payload 0xFF.
- Overflow: push 5 requests with DEPTH=4 while the transmitter stalls; the first is popped into SEND. Sixth request → `overflow` pulse, `fifo_count`=4; all 5 accepted frames emerge in order.
- Reset while in SEND with 2 queued → outputs at reset values; no `d_done`; later `data_transmitted` is ignored.
